// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA channel controller: AHB transfer
// encodings, channel FSM states and bus constants.
package dmac_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_BURST,
    ST_RD_LAST,
    ST_WR_BURST,
    ST_WR_LAST,
    ST_ERR
  } chan_state_t;

  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/dmac_chan_ctrl_v2_beat_calc.sv
// Combinational beat count for the next read/write burst pair.
// DMAC_1KB_BOUNDARY_EN additionally stops bursts at 1 KB address boundaries.
module dmac_beat_calc
  import dmac_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int BL_W   = 5
) (
  input  logic [BL_W-1:0]   burst_len,
  input  logic [CNT_W-1:0]  remaining,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              src_inc,
  input  logic              dst_inc,
  output logic [BL_W-1:0]   beats
);

  localparam logic [BL_W-1:0] MAX_BL = BL_W'(2 ** (BL_W - 1));

  logic [BL_W-1:0]  bl_clamped;
  logic [CNT_W-1:0] lim;
  logic             unused_ok;

  assign unused_ok = ^{src_addr, dst_addr, src_inc, dst_inc};

`ifdef DMAC_1KB_BOUNDARY_EN
  // Words left before the next 1 KB boundary: 1..256.
  logic [8:0] src_room;
  logic [8:0] dst_room;
  assign src_room = 9'd256 - {1'b0, src_addr[9:2]};
  assign dst_room = 9'd256 - {1'b0, dst_addr[9:2]};
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    bl_clamped = burst_len;
    if (burst_len == '0)
      bl_clamped = BL_W'(1);
    else if (burst_len > MAX_BL)
      bl_clamped = MAX_BL;
    lim = CNT_W'(bl_clamped);
    if (remaining < lim)
      lim = remaining;
`ifdef DMAC_1KB_BOUNDARY_EN
    if (src_inc && (CNT_W'(src_room) < lim))
      lim = CNT_W'(src_room);
    if (dst_inc && (CNT_W'(dst_room) < lim))
      lim = CNT_W'(dst_room);
`endif
    beats = BL_W'(lim);
  end

endmodule

// File: rtl/dmac_chan_ctrl_v2.sv
// DMA channel controller: moves words as read-burst/write-burst pairs through
// the channel FIFO. Optional macro DMAC_1KB_BOUNDARY_EN (see dmac_beat_calc).
module dmac_chan_ctrl_v2
  import dmac_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int BL_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              src_inc,
  input  logic              dst_inc,
  input  logic [CNT_W-1:0]  xfer_len,
  input  logic [BL_W-1:0]   burst_len,
  input  logic              M_HReady,
  input  logic [1:0]        M_HResp,
  input  logic              fifo_empty,
  output logic [ADDR_W-1:0] HAddr,
  output logic [1:0]        HTrans,
  output logic              HWrite,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              irq,
  output logic [CNT_W-1:0]  remaining
);

  chan_state_t       state, state_nx;
  logic [ADDR_W-1:0] src_cnt, dst_cnt;
  logic              src_inc_q, dst_inc_q;
  logic [BL_W-1:0]   issued, burst_beats, calc_beats, cur_beats;
  logic              dphase_q, abort_seen, err_pulse, zero_done;
  logic              issue, addr_ok, data_ok, resp_err, last_addr, finish;
  logic [CNT_W-1:0]  rem_after;

  dmac_beat_calc #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .BL_W(BL_W)) u_beat_calc (
    .burst_len (burst_len),
    .remaining (remaining),
    .src_addr  (src_cnt),
    .dst_addr  (dst_cnt),
    .src_inc   (src_inc_q),
    .dst_inc   (dst_inc_q),
    .beats     (calc_beats)
  );

  // A read burst only opens on an empty FIFO; once begun it runs to the end.
  assign issue     = (state == ST_RD_BURST && (issued != '0 || fifo_empty)) ||
                     (state == ST_WR_BURST);
  assign addr_ok   = issue && M_HReady;
  assign data_ok   = dphase_q && M_HReady && (M_HResp == HRESP_OKAY);
  assign resp_err  = dphase_q && (M_HResp != HRESP_OKAY) && (state != ST_ERR);
  assign cur_beats = (state == ST_RD_BURST && issued == '0) ? calc_beats : burst_beats;
  assign last_addr = addr_ok && (issued + BL_W'(1) == cur_beats);
  assign rem_after = remaining - CNT_W'(burst_beats);
  assign finish    = (state == ST_WR_LAST) && data_ok &&
                     (rem_after == '0 || abort_seen || abort);

  assign HTrans = !issue ? HTRANS_IDLE : (issued == '0 ? HTRANS_NONSEQ : HTRANS_SEQ);
  assign HAddr  = (state == ST_WR_BURST) ? dst_cnt : src_cnt;
  assign HWrite = (state == ST_WR_BURST);
  assign busy   = (state != ST_IDLE);
  assign done   = finish || zero_done;
  assign irq    = done || err_pulse;

  always_comb begin
    state_nx   = state;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nx = (xfer_len == '0) ? ST_IDLE : ST_RD_BURST;
      ST_RD_BURST: begin
        fifo_wr_en = data_ok;
        if (last_addr) state_nx = ST_RD_LAST;
      end
      ST_RD_LAST:  begin
        fifo_wr_en = data_ok;
        if (data_ok) state_nx = ST_WR_BURST;
      end
      ST_WR_BURST: begin
        fifo_rd_en = addr_ok;
        if (last_addr) state_nx = ST_WR_LAST;
      end
      ST_WR_LAST:  if (data_ok) state_nx = finish ? ST_IDLE : ST_RD_BURST;
      ST_ERR:      if (M_HReady) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
    // An error response overrides everything: bus goes idle, FIFO untouched.
    if (resp_err) begin
      state_nx   = ST_ERR;
      fifo_wr_en = 1'b0;
      fifo_rd_en = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      src_cnt     <= '0;
      dst_cnt     <= '0;
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      issued      <= '0;
      burst_beats <= '0;
      dphase_q    <= 1'b0;
      abort_seen  <= 1'b0;
      err_pulse   <= 1'b0;
      zero_done   <= 1'b0;
      err         <= 1'b0;
      remaining   <= '0;
    end else begin
      state     <= state_nx;
      zero_done <= (state == ST_IDLE) && start && (xfer_len == '0);
      err_pulse <= resp_err;
      dphase_q  <= resp_err ? 1'b0 : (M_HReady ? addr_ok : dphase_q);
      if (resp_err) err <= 1'b1;
      if (state != ST_IDLE && abort) abort_seen <= 1'b1;
      if (state == ST_IDLE && start) begin
        src_cnt    <= src_addr;
        dst_cnt    <= dst_addr;
        src_inc_q  <= src_inc;
        dst_inc_q  <= dst_inc;
        remaining  <= xfer_len;
        issued     <= '0;
        err        <= 1'b0;
        abort_seen <= 1'b0;
      end
      if (addr_ok) begin
        issued <= last_addr ? '0 : issued + BL_W'(1);
        if (state == ST_RD_BURST) begin
          if (issued == '0) burst_beats <= calc_beats;
          if (src_inc_q) src_cnt <= src_cnt + ADDR_W'(WORD_BYTES);
        end else if (dst_inc_q) begin
          dst_cnt <= dst_cnt + ADDR_W'(WORD_BYTES);
        end
      end
      if (state == ST_WR_LAST && data_ok) remaining <= rem_after;
    end
  end

endmodule

// File: tb/tb_dmac_chan_ctrl_v2.sv
// Self-checking bench for dmac_chan_ctrl_v2: directed scenarios plus random
// transfers compared against a transaction-level model of accepted addresses.
module tb_dmac_chan_ctrl_v2;

  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst, start, abort, src_inc, dst_inc, M_HReady, fifo_empty;
  logic [31:0] src_addr, dst_addr, HAddr;
  logic [15:0] xfer_len, remaining;
  logic [4:0]  burst_len;
  logic [1:0]  M_HResp, HTrans;
  logic        HWrite, fifo_wr_en, fifo_rd_en, busy, done, err, irq;

  dmac_chan_ctrl_v2 dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .src_inc(src_inc), .dst_inc(dst_inc),
    .xfer_len(xfer_len), .burst_len(burst_len), .M_HReady(M_HReady), .M_HResp(M_HResp),
    .fifo_empty(fifo_empty), .HAddr(HAddr), .HTrans(HTrans), .HWrite(HWrite),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .busy(busy), .done(done),
    .err(err), .irq(irq), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor-owned totals; the main flow works with deltas around each run.
  logic [32:0] acc_q[$];
  int wr_tot = 0, rd_tot = 0, done_tot = 0, irq_tot = 0, stab_cnt = 0, stab_bad = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [1:0]  prev_trans = '0;
  int          fifo_occ = 0;
  logic        force_full = 1'b0;

  assign fifo_empty = !force_full && (fifo_occ == 0);

  always @(posedge clk or posedge rst)
    if (rst) fifo_occ <= 0;
    else     fifo_occ <= fifo_occ + int'(fifo_wr_en) - int'(fifo_rd_en);

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (HTrans[1] && M_HReady) acc_q.push_back({HWrite, HAddr});
      wr_tot   <= wr_tot + int'(fifo_wr_en);
      rd_tot   <= rd_tot + int'(fifo_rd_en);
      done_tot <= done_tot + int'(done);
      irq_tot  <= irq_tot + int'(irq);
      if (prev_wait) begin
        stab_cnt <= stab_cnt + 1;
        if (HAddr !== prev_addr || HTrans !== prev_trans) stab_bad <= stab_bad + 1;
      end
      prev_wait  <= HTrans[1] && !M_HReady;
      prev_addr  <= HAddr;
      prev_trans <= HTrans;
    end else begin
      prev_wait <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the list of accepted bus addresses a transfer should make.
  logic [32:0] exp_q[$];
  int          exp_rem;

  task automatic model(input logic [31:0] s_in, input logic [31:0] d_in, input bit si,
                       input bit di, input int len, input int bl, input int abort_after);
    logic [31:0] s, d;
    int rem, n, mb;
    s = s_in; d = d_in; rem = len; n = 0;
    mb = (bl == 0) ? 1 : ((bl > 16) ? 16 : bl);
    exp_q.delete();
    while (rem > 0 && !(abort_after > 0 && n >= abort_after)) begin
      int b;
      b = (mb < rem) ? mb : rem;
`ifdef DMAC_1KB_BOUNDARY_EN
      if (si && int'((1024 - (s % 1024)) / 4) < b) b = int'((1024 - (s % 1024)) / 4);
      if (di && int'((1024 - (d % 1024)) / 4) < b) b = int'((1024 - (d % 1024)) / 4);
`endif
      for (int i = 0; i < b; i++) begin
        exp_q.push_back({1'b0, s});
        if (si) s = s + 32'd4;
      end
      for (int i = 0; i < b; i++) begin
        exp_q.push_back({1'b1, d});
        if (di) d = d + 32'd4;
      end
      rem -= b;
      n++;
    end
    exp_rem = rem;
  endtask

  // Per-run results.
  int   done_cyc, base_acc, base_wr, base_rd, base_done, base_irq, base_sc, base_sb;
  logic timed_out;
  logic [1:0] trans_tr[64];
  logic       irq_tr[64], err_tr[64], busy_tr[64];

  task automatic run(input logic [31:0] s, input logic [31:0] d, input bit si, input bit di,
                     input int len, input int bl, input bit rand_rdy, input int lo_from,
                     input int lo_to, input int abort_from, input int err_at,
                     input int full_to, input int rst_at);
    int c;
    base_acc = acc_q.size(); base_wr = wr_tot; base_rd = rd_tot;
    base_done = done_tot; base_irq = irq_tot; base_sc = stab_cnt; base_sb = stab_bad;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; src_inc = si; dst_inc = di;
    xfer_len = 16'(len); burst_len = 5'(bl);
    M_HReady = 1'b1; M_HResp = 2'b00; abort = 1'b0; force_full = 1'b0;
    for (c = 1; c < BUDGET; c++) begin
      @(negedge clk);
      start      = 1'b0;
      M_HReady   = rand_rdy ? ($urandom_range(0, 3) != 0) : !(c >= lo_from && c <= lo_to);
      M_HResp    = (c == err_at) ? 2'b10 : 2'b00;
      abort      = (abort_from >= 0 && c >= abort_from);
      force_full = (c <= full_to);
      if (c == rst_at) rst = 1'b1;
      #1;
      if (c < 64) begin
        trans_tr[c] = HTrans; irq_tr[c] = irq; err_tr[c] = err; busy_tr[c] = busy;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (!busy && c >= 2) break;
    end
    timed_out = (c >= BUDGET);
    @(negedge clk);
    rst = 1'b0; abort = 1'b0; M_HReady = 1'b1; M_HResp = 2'b00; force_full = 1'b0;
    #2;
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_n_acc"}, 64'(acc_q.size() - base_acc), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base_acc + i < acc_q.size(); i++)
      check({tag, "_acc"}, 64'(acc_q[base_acc + i]), 64'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_addr = '0; dst_addr = '0;
    src_inc = 1'b0; dst_inc = 1'b0; xfer_len = '0; burst_len = '0;
    M_HReady = 1'b1; M_HResp = 2'b00;
    @(negedge clk); @(negedge clk); #1;
    check("rst_htrans", 64'(HTrans), 64'(0));
    check("rst_haddr", 64'(HAddr), 64'(0));
    check("rst_flags", 64'({HWrite, fifo_wr_en, fifo_rd_en, busy, done, err, irq}), 64'(0));
    check("rst_remaining", 64'(remaining), 64'(0));
    @(negedge clk); rst = 1'b0;

    // Two 4-beat pairs, zero-wait.
    run(32'h100, 32'h200, 1, 1, 8, 4, 0, -1, -1, -1, -1, 0, -1);
    model(32'h100, 32'h200, 1, 1, 8, 4, 0);
    check("t1_timeout", 64'(timed_out), 64'(0));
    check_acc("t1");
    check("t1_done_cyc", 64'(done_cyc), 64'(20));
    check("t1_remaining", 64'(remaining), 64'(exp_rem));
    check("t1_wr", 64'(wr_tot - base_wr), 64'(8));
    check("t1_rd", 64'(rd_tot - base_rd), 64'(8));
    check("t1_irq", 64'(irq_tot - base_irq), 64'(1));

    // Error response on read beat 2 of 4.
    run(32'h100, 32'h200, 1, 1, 4, 4, 0, -1, -1, -1, 3, 0, -1);
    check("t2_timeout", 64'(timed_out), 64'(0));
    check("t2_err_before", 64'(err_tr[3]), 64'(0));
    check("t2_htrans_next", 64'(trans_tr[4]), 64'(0));
    check("t2_err", 64'(err_tr[4]), 64'(1));
    check("t2_irq", 64'(irq_tr[4]), 64'(1));
    check("t2_irq_cnt", 64'(irq_tot - base_irq), 64'(1));
    check("t2_wr", 64'(wr_tot - base_wr), 64'(1));
    check("t2_rd", 64'(rd_tot - base_rd), 64'(0));
    check("t2_done", 64'(done_tot - base_done), 64'(0));
    check("t2_remaining", 64'(remaining), 64'(4));
    check("t2_err_sticky", 64'(err), 64'(1));

    // Zero-length start: done/irq next cycle, bus idle, err cleared.
    run(32'h0, 32'h0, 1, 1, 0, 4, 0, -1, -1, -1, -1, 0, -1);
    check("t3_done_cyc", 64'(done_cyc), 64'(1));
    check("t3_irq", 64'(irq_tr[1]), 64'(1));
    check("t3_err_clr", 64'(err_tr[1]), 64'(0));
    check("t3_n_acc", 64'(acc_q.size() - base_acc), 64'(0));

    // Reset in the middle of a read burst.
    run(32'h100, 32'h200, 1, 1, 8, 4, 0, -1, -1, -1, -1, 0, 3);
    check("t4_busy", 64'(busy_tr[3]), 64'(0));
    check("t4_htrans", 64'(trans_tr[3]), 64'(0));
    check("t4_done", 64'(done_tot - base_done), 64'(0));
    check("t4_remaining", 64'(remaining), 64'(0));

    // Abort during burst 1 of 3.
    run(32'h1000, 32'h2000, 1, 1, 12, 4, 0, -1, -1, 2, -1, 0, -1);
    model(32'h1000, 32'h2000, 1, 1, 12, 4, 1);
    check_acc("t5");
    check("t5_done_cyc", 64'(done_cyc), 64'(10));
    check("t5_remaining", 64'(remaining), 64'(exp_rem));

    // Three wait states on write beat 1.
    run(32'h300, 32'h400, 1, 1, 4, 4, 0, 6, 8, -1, -1, 0, -1);
    model(32'h300, 32'h400, 1, 1, 4, 4, 0);
    check_acc("t6");
    check("t6_rd", 64'(rd_tot - base_rd), 64'(4));
    check("t6_stab_cnt", 64'(stab_cnt - base_sc), 64'(3));
    check("t6_stab_bad", 64'(stab_bad - base_sb), 64'(0));
    check("t6_done_cyc", 64'(done_cyc), 64'(13));

    // FIFO not empty for three cycles delays the read burst.
    run(32'h500, 32'h600, 0, 1, 4, 4, 0, -1, -1, -1, -1, 3, -1);
    model(32'h500, 32'h600, 0, 1, 4, 4, 0);
    check_acc("t7");
    check("t7_idle", 64'(trans_tr[3]), 64'(0));
    check("t7_nonseq", 64'(trans_tr[4]), 64'(2));
    check("t7_done_cyc", 64'(done_cyc), 64'(13));

    // Across 0x400 (split into 2 + 6 beats when the boundary clamp is built in).
    run(32'h3F8, 32'h800, 1, 1, 8, 8, 0, -1, -1, -1, -1, 0, -1);
    model(32'h3F8, 32'h800, 1, 1, 8, 8, 0);
    check_acc("t8");
    check("t8_remaining", 64'(remaining), 64'(0));

    // Random transfers with random wait states.
    for (int k = 0; k < 8; k++) begin
      logic [31:0] s, d;
      bit si, di;
      int len, bl;
      s   = (k == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      d   = $urandom() & 32'hFFFF_FFFC;
      si  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      di  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      bl  = $urandom_range(0, 31);
      run(s, d, si, di, len, bl, 1, -1, -1, -1, -1, 0, -1);
      model(s, d, si, di, len, bl, 0);
      check("rnd_timeout", 64'(timed_out), 64'(0));
      check_acc("rnd");
      check("rnd_wr", 64'(wr_tot - base_wr), 64'(len));
      check("rnd_rd", 64'(rd_tot - base_rd), 64'(len));
      check("rnd_done", 64'(done_tot - base_done), 64'(1));
      check("rnd_remaining", 64'(remaining), 64'(exp_rem));
      check("rnd_stab_bad", 64'(stab_bad - base_sb), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
